execute_div: RTL and testbench

- Iterative radix-2 restoring divider for the execute stage; the companion of the pipelined multiplier.
- Implements 32/32 -> 32 quotient, signed and unsigned, with overflow flag.
- Multi-cycle: EXE issues a start pulse, stalls on busy, and captures the result when done pulses.

---
 rtl/execute_div.sv | 154 +++++++++++++++
 tb/tb_execute_div.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/execute_div.sv
// Iterative radix-2 restoring divider (32/32 -> 32 quotient, signed/unsigned, overflow flag).
// Optional macro EXECUTE_DIV_EARLY_EXIT_EN: skip RUN on overflow or |a| < |b|.
`ifndef EXOP_DIV_AB
`define EXOP_DIV_AB   6'h1A
`endif
`ifndef EXOP_DIV_U_AB
`define EXOP_DIV_U_AB 6'h1B
`endif
`ifndef REGSZ
`define REGSZ 32
`endif

module execute_div #(
   parameter int WIDTH = `REGSZ
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [5:0]       div_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] out,
   output logic             ov,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] dvd_r, dsr_r, rem_r, quo_r, out_r;
   logic [CW-1:0]    cnt_r;
   logic             qs_r, ovf_r, ov_r, busy_r, done_r;

   logic             signed_s, ovf_s, qs_s, early_s, accept_s, ge_s;
   logic [WIDTH-1:0] mag_a_s, mag_b_s;
   logic [WIDTH:0]   rem_sh_s, diff_s;

   // Two's-complement magnitude; the most negative value maps onto itself as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
      abs_f = v[WIDTH-1] ? (ZERO_W - v) : v;
   endfunction

   // Start-cycle decode of operands, quotient sign and overflow.
   always_comb begin
      signed_s = (div_op == `EXOP_DIV_AB);
      mag_a_s  = signed_s ? abs_f(in_a) : in_a;
      mag_b_s  = signed_s ? abs_f(in_b) : in_b;
      ovf_s    = (in_b == ZERO_W) | (signed_s & (in_a == MIN_W) & (in_b == ONES_W));
      qs_s     = signed_s & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
`ifdef EXECUTE_DIV_EARLY_EXIT_EN
      early_s  = ovf_s | (mag_a_s < mag_b_s);
`else
      early_s  = 1'b0;
`endif
      accept_s = (state_r == ST_IDLE) & enable;
   end

   // One restoring step; the extra remainder bit keeps divisors above 2^(WIDTH-1) exact.
   always_comb begin
      rem_sh_s = {rem_r, dvd_r[WIDTH-1]};
      diff_s   = rem_sh_s - {1'b0, dsr_r};
      ge_s     = ~diff_s[WIDTH];
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_s;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_s = early_s ? ST_FIX : ST_RUN;
            else          state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (cnt_r == CW'(1)) state_s = ST_FIX;
            else                 state_s = ST_RUN;
         end
         ST_FIX:  state_s = ST_DONE;
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dvd_r  <= ZERO_W;
         dsr_r  <= ZERO_W;
         rem_r  <= ZERO_W;
         quo_r  <= ZERO_W;
         cnt_r  <= {CW{1'b0}};
         qs_r   <= 1'b0;
         ovf_r  <= 1'b0;
         out_r  <= ZERO_W;
         ov_r   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (accept_s) begin
                  dvd_r  <= mag_a_s;
                  dsr_r  <= mag_b_s;
                  rem_r  <= ZERO_W;
                  quo_r  <= ZERO_W;
                  cnt_r  <= CNT_INIT;
                  qs_r   <= qs_s;
                  ovf_r  <= ovf_s;
                  busy_r <= 1'b1;
               end
            end
            ST_RUN: begin
               dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
               rem_r <= ge_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
               quo_r <= {quo_r[WIDTH-2:0], ge_s};
               cnt_r <= cnt_r - CW'(1);
            end
            ST_FIX: begin
               out_r  <= ovf_r ? ZERO_W : (qs_r ? (ZERO_W - quo_r) : quo_r);
               ov_r   <= ovf_r;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
            ST_DONE: done_r <= 1'b0;
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign out  = out_r;
   assign ov   = ov_r;
   assign busy = busy_r;
   assign done = done_r;
endmodule

// File: tb/tb_execute_div.sv
// Self-checking bench for execute_div: directed cases plus random operations against an arithmetic model.
`ifndef EXOP_DIV_AB
`define EXOP_DIV_AB   6'h1A
`endif
`ifndef EXOP_DIV_U_AB
`define EXOP_DIV_U_AB 6'h1B
`endif

module tb_execute_div;
   localparam logic [5:0] OP_S = `EXOP_DIV_AB;
   localparam logic [5:0] OP_U = `EXOP_DIV_U_AB;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [5:0]  div_op = 6'd0;
   logic [31:0] in_a = 32'd0;
   logic [31:0] in_b = 32'd0;
   logic [31:0] out;
   logic        ov, busy, done;

   int n_checks = 0;
   int n_fails  = 0;

   execute_div #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .enable(enable), .div_op(div_op),
      .in_a(in_a), .in_b(in_b), .out(out), .ov(ov), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic, division truncating toward zero.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                        output logic [31:0] q, output logic o, output int lat);
      longint sa, sb, ma, mb;
      bit sg;
      sg = (op == OP_S);
      sa = sg ? longint'($signed(a)) : longint'(a);
      sb = sg ? longint'($signed(b)) : longint'(b);
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      o  = (sb == 0) || (sg && sa == -64'sd2147483648 && sb == -64'sd1);
      q  = o ? 32'd0 : 32'(sa / sb);
`ifdef EXECUTE_DIV_EARLY_EXIT_EN
      lat = (o || ma < mb) ? 2 : 34;
`else
      lat = 34;
`endif
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                         input int pulse_at, input string tag);
      logic [31:0] q;
      logic        o;
      int          lat, n, busy_cnt;
      bit          got;
      model(a, b, op, q, o, lat);
      @(negedge clk);
      enable = 1'b1; in_a = a; in_b = b; div_op = op;
      @(negedge clk);
      enable = 1'b0; in_a = $urandom; in_b = $urandom; div_op = 6'($urandom);
      n = 1; busy_cnt = 0; got = 1'b0;
      while (n <= 100 && !got) begin
         if (done === 1'b1) got = 1'b1;
         else begin
            if (busy === 1'b1) busy_cnt++;
            if (n == pulse_at) begin
               enable = 1'b1; in_a = 32'd1000; in_b = 32'd3; div_op = OP_U;
            end else enable = 1'b0;
            @(negedge clk);
            n++;
         end
      end
      enable = 1'b0;
      check($sformatf("%s/done", tag), 32'(got), 32'd1);
      check($sformatf("%s/lat", tag), 32'(n), 32'(lat));
      check($sformatf("%s/busycnt", tag), 32'(busy_cnt), 32'(lat - 1));
      check($sformatf("%s/busy_at_done", tag), 32'(busy), 32'd0);
      check($sformatf("%s/out", tag), out, q);
      check($sformatf("%s/ov", tag), 32'(ov), 32'(o));
      // A start presented while the result is being delivered must be ignored.
      enable = 1'b1; in_a = $urandom; in_b = 32'd1; div_op = OP_U;
      @(negedge clk);
      enable = 1'b0;
      check($sformatf("%s/done_pulse", tag), 32'(done), 32'd0);
      check($sformatf("%s/no_restart", tag), 32'(busy), 32'd0);
      check($sformatf("%s/hold", tag), out, q);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [5:0]  rop;
      int          sel, done_seen;

      repeat (3) @(negedge clk);
      check("reset/out", out, 32'd0);
      check("reset/ov", 32'(ov), 32'd0);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      reset = 1'b0;

      run_op(32'd100, 32'd7, OP_U, 0, "u100_7");
      run_op(32'hFFFFFF9C, 32'd7, OP_S, 0, "sneg_pos");
      run_op(32'd100, 32'hFFFFFFF9, OP_S, 0, "spos_neg");
      run_op(32'hFFFFFF9C, 32'hFFFFFFF9, OP_S, 0, "sneg_neg");
      run_op(32'h80000000, 32'hFFFFFFFF, OP_S, 0, "s_ovf");
      run_op(32'h80000000, 32'hFFFFFFFF, OP_U, 0, "u_minus1");
      run_op(32'h12345678, 32'd0, OP_S, 0, "s_div0");
      run_op(32'h12345678, 32'd0, OP_U, 0, "u_div0");
      run_op(32'h80000000, 32'd1, OP_S, 0, "smin_1");
      run_op(32'd0, 32'hFFFFFFF9, OP_S, 0, "zero_neg");
      run_op(32'hFFFFFFFF, 32'h80000001, OP_U, 0, "u_bigdiv");
      run_op(32'd5, 32'd9, OP_U, 0, "u5_9");
      run_op(32'd9, 32'd5, OP_U, 0, "u9_5");
      run_op(32'd100, 32'd7, 6'h3F, 0, "other_op");
      run_op(32'd100, 32'd7, OP_U, 5, "ignore_mid");

      // Reset in the middle of an operation.
      @(negedge clk);
      enable = 1'b1; in_a = 32'd100; in_b = 32'd7; div_op = OP_U;
      @(negedge clk);
      enable = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst/out", out, 32'd0);
      check("midrst/ov", 32'(ov), 32'd0);
      check("midrst/busy", 32'(busy), 32'd0);
      check("midrst/done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      check("midrst/no_done", 32'(done_seen), 32'd0);
      run_op(32'd100, 32'd7, OP_U, 0, "after_rst");

      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 9);
         rop = (sel < 4) ? OP_S : ((sel < 8) ? OP_U : 6'($urandom));
         ra  = $urandom;
         sel = $urandom_range(0, 7);
         rb  = (sel == 0) ? 32'd0 : ((sel < 3) ? 32'($urandom_range(1, 300)) : 32'($urandom));
         if (sel == 7) begin
            ra = 32'h80000000; rb = 32'hFFFFFFFF;
         end
         run_op(ra, rb, rop, 0, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
